regmux_seq3: RTL and testbench
==============================

Name: regmux_seq3

Overview:
Gathering counterpart of the registered 1-to-8 scatter stage in the RSA datapath. It snapshots eight RSA_DW-wide lane registers on a start pulse, then serializes a contiguous, wrap-around window of those lanes onto one output stream. The output stream uses a valid/ready handshake. It sits between the systolic-array result lanes and a single-port consumer, such as a memory writer or the next PE column.

Parameters:
RSA_DW, 16, data width of each lane and of dout
LANES, 8, number of lanes (fixed by the 3-bit select; not to be overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  synchronous reset, active-low
en  input  1  block enable; low acts as synchronous clear, same effect as reset
start  input  1  single-cycle request to begin a transfer
start_sel  input  3  index of the first lane to emit
len  input  3  number of beats minus 1 (0 gives 1 beat, 7 gives 8 beats)
din_000 .. din_111  input  RSA_DW each  eight lane inputs, sampled only on an accepted start
dout  output  RSA_DW  current beat data
dout_sel  output  3  lane index of the current beat
dout_valid  output  1  beat present on dout
dout_ready  input  1  consumer accepts the beat when high together with dout_valid
dout_last  output  1  final beat of the transfer
busy  output  1  transfer in progress
done  output  1  single-cycle pulse after the last beat is accepted

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (sys_rst_n).
- Clear condition: sys_rst_n==0 or en==0 at a clock edge clears everything to zero:
  - dout, dout_sel, dout_valid, dout_last, busy, done
  - the internal snapshot bank, beat counter and lane pointer
  - the state register, which goes to IDLE
- The clear has priority over every other input. Asserting it mid-transfer aborts the transfer immediately, with no done pulse.
- State machine has two states, IDLE and EMIT.
- IDLE:
  - busy=0, dout_valid=0.
  - If start==1 at edge t: snapshot all eight din_xxx into the bank, set ptr=start_sel and remain=len, then go to EMIT.
  - Outputs at t+1: dout_valid=1, dout=bank[start_sel], dout_sel=start_sel, dout_last=(len==0), busy=1. Start-to-first-beat latency is 1 cycle.
- EMIT:
  - dout and dout_sel always reflect bank[ptr] and ptr, registered.
  - While dout_valid=1 and dout_ready=0, dout, dout_sel and dout_last hold stable.
  - On an accepted beat (dout_valid & dout_ready) with remain!=0: ptr<=ptr+1 modulo 8 (111 wraps to 000), remain<=remain-1, and the next beat is presented the following cycle.
  - dout_last=1 exactly when remain==0.
  - On an accepted beat with remain==0:
    - next cycle: state IDLE, dout_valid=0, busy=0, done=1 for one cycle;
    - dout and dout_sel keep their last values until the next start or clear.
- Throughput is one beat per cycle when dout_ready is held high. A full 8-beat transfer takes 8 accepted cycles after the start latency.
- start while busy=1 is ignored, including the cycle in which the last beat is accepted. Minimum spacing is start, transfer, done cycle, then a new start is accepted in the done cycle or later.
- din_xxx changes after the start edge do not affect the transfer.
- done and dout_valid are never high in the same cycle.
- Widths: ptr is 3 bits with natural wrap. remain is 3 bits and never underflows, because it is only decremented when nonzero.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE and ST_EMIT;
  - LANES=8 and the lane-index width 3;
  - the beat-count width.
- Single module. The snapshot bank and lane read mux are inline, with no sub-module; the bank is a plain 8-entry register array indexed by ptr.

Test Plan:
- Basic full transfer: lanes = 0x0000..0x0007, start_sel=0, len=7, dout_ready=1. Expect dout 0..7 on consecutive cycles starting one cycle after start, dout_sel 0..7, dout_last only on beat 7, done one cycle after that beat.
- Wrap-around: start_sel=6, len=3. Expect dout_sel sequence 6,7,0,1 with matching lane data and dout_last on the lane-1 beat.
- Backpressure: hold dout_ready=0 for 3 cycles on beat 2 of an 8-beat transfer. Expect dout, dout_sel and dout_last frozen for those cycles, no beat lost or duplicated, done delayed by 3 cycles.
- Single beat and snapshot: len=0, start_sel=5; change din_101 the cycle after start. Expect one beat carrying the old din_101 value, dout_last=1 on it, done next cycle.
- start while busy: pulse start mid-transfer and again in the cycle the last beat is accepted. Both are ignored; a start in the done cycle begins a new transfer with first beat 1 cycle later.
- Clear mid-op: drop en (then separately sys_rst_n) for one cycle during beat 4. Expect all outputs 0 the following cycle, state IDLE, no done pulse, and a fresh start working normally afterwards.

Source files
------------

// File: rtl/regmux_seq3_pkg.sv
// Shared constants for the regmux_seq3 lane gather/serialize stage.
package regmux_seq3_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/regmux_seq3.sv
// Snapshots eight lanes on start and streams a wrap-around window of them
// out over a valid/ready handshake, one beat per accepted cycle.
module regmux_seq3
  import regmux_seq3_pkg::*;
#(
  parameter int RSA_DW = 16
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [2:0]        start_sel,
  input  logic [2:0]        len,
  input  logic [RSA_DW-1:0] din_000,
  input  logic [RSA_DW-1:0] din_001,
  input  logic [RSA_DW-1:0] din_010,
  input  logic [RSA_DW-1:0] din_011,
  input  logic [RSA_DW-1:0] din_100,
  input  logic [RSA_DW-1:0] din_101,
  input  logic [RSA_DW-1:0] din_110,
  input  logic [RSA_DW-1:0] din_111,
  output logic [RSA_DW-1:0] dout,
  output logic [2:0]        dout_sel,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  state_t                  state_r;
  logic [RSA_DW-1:0]       bank_r [LANES];
  logic [SEL_W-1:0]        ptr_r;
  logic [CNT_W-1:0]        remain_r;
  logic [RSA_DW-1:0]       dout_r;
  logic                    valid_r;
  logic                    last_r;
  logic                    busy_r;
  logic                    done_r;
  logic [RSA_DW-1:0]       lane_s [LANES];
  logic [SEL_W-1:0]        nxt_ptr_s;

  // Gather the lane inputs into an indexable array and precompute the next lane.
  always_comb begin
    lane_s[0] = din_000;
    lane_s[1] = din_001;
    lane_s[2] = din_010;
    lane_s[3] = din_011;
    lane_s[4] = din_100;
    lane_s[5] = din_101;
    lane_s[6] = din_110;
    lane_s[7] = din_111;
    nxt_ptr_s = ptr_r + 3'd1;
  end

  // Control FSM, snapshot bank and registered output stream.
  always_ff @(posedge clk) begin
    if (!sys_rst_n || !en) begin
      state_r  <= ST_IDLE;
      for (int i = 0; i < LANES; i++) bank_r[i] <= '0;
      ptr_r    <= 3'd0;
      remain_r <= 3'd0;
      dout_r   <= '0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < LANES; i++) bank_r[i] <= lane_s[i];
            ptr_r    <= start_sel;
            remain_r <= len;
            dout_r   <= lane_s[start_sel];
            last_r   <= (len == 3'd0);
            valid_r  <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (valid_r && dout_ready) begin
            if (remain_r != 3'd0) begin
              ptr_r    <= nxt_ptr_s;
              remain_r <= remain_r - 3'd1;
              dout_r   <= bank_r[nxt_ptr_s];
              last_r   <= (remain_r == 3'd1);
            end else begin
              // dout and dout_sel deliberately keep the final beat
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_r;
  assign dout_sel   = ptr_r;
  assign dout_valid = valid_r;
  assign dout_last  = last_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_regmux_seq3.sv
// Directed bench for regmux_seq3: a beat-index transfer model is checked
// against the DUT every cycle, plus literal spot checks on key beats.
module tb_regmux_seq3;
  logic        clk = 1'b0;
  logic        sys_rst_n, en, start, dout_ready;
  logic [2:0]  start_sel, len;
  logic [15:0] din [8];
  logic [15:0] dout;
  logic [2:0]  dout_sel;
  logic        dout_valid, dout_last, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  // transfer model: beat index within a window, not a remain counter
  bit          m_busy, m_done;
  int          m_beat, m_len, m_first;
  logic [15:0] m_snap [8];
  logic [15:0] m_dout;
  int          m_sel;

  regmux_seq3 #(.RSA_DW(16)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .en(en), .start(start),
    .start_sel(start_sel), .len(len),
    .din_000(din[0]), .din_001(din[1]), .din_010(din[2]), .din_011(din[3]),
    .din_100(din[4]), .din_101(din[5]), .din_110(din[6]), .din_111(din[7]),
    .dout(dout), .dout_sel(dout_sel), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!sys_rst_n || !en) begin
      m_busy = 1'b0; m_done = 1'b0; m_beat = 0; m_len = 0; m_first = 0;
      for (int i = 0; i < 8; i++) m_snap[i] = 16'h0000;
      m_dout = 16'h0000; m_sel = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      if (dout_ready) begin
        if (m_beat == m_len) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_beat++;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        for (int i = 0; i < 8; i++) m_snap[i] = din[i];
        m_first = int'(start_sel);
        m_len   = int'(len);
        m_beat  = 0;
        m_busy  = 1'b1;
      end
    end
    if (m_busy) begin
      m_sel  = (m_first + m_beat) % 8;
      m_dout = m_snap[m_sel];
    end
  endtask

  // one clock: DUT and model both consume the current inputs, then compare
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_busy});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("dout_last", {31'd0, dout_last}, {31'd0, (m_busy && m_beat == m_len)});
    chk("dout_sel", {29'd0, dout_sel}, m_sel[31:0]);
    chk("dout", {16'd0, dout}, {16'd0, m_dout});
    chk("done_valid_excl", {31'd0, (done & dout_valid)}, 32'd0);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic go(input logic [2:0] sel, input logic [2:0] l);
    start = 1'b1; start_sel = sel; len = l;
    step();
    start = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0; en = 1'b1; start = 1'b0; start_sel = 3'd0; len = 3'd0;
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 16'(i);
    steps(2);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    sys_rst_n = 1'b1;
    step();

    // basic full transfer
    go(3'd0, 3'd7);
    chk("basic_b0_dout", {16'd0, dout}, 32'h0000_0000);
    chk("basic_b0_valid", {31'd0, dout_valid}, 32'd1);
    steps(7);
    chk("basic_b7_dout", {16'd0, dout}, 32'h0000_0007);
    chk("basic_b7_last", {31'd0, dout_last}, 32'd1);
    step();
    chk("basic_done", {31'd0, done}, 32'd1);
    steps(2);

    // wrap-around window 6,7,0,1
    for (int i = 0; i < 8; i++) din[i] = 16'h1000 + 16'(i);
    go(3'd6, 3'd3);
    chk("wrap_b0_sel", {29'd0, dout_sel}, 32'd6);
    steps(2);
    chk("wrap_b2_sel", {29'd0, dout_sel}, 32'd0);
    step();
    chk("wrap_b3_dout", {16'd0, dout}, 32'h0000_1001);
    chk("wrap_b3_last", {31'd0, dout_last}, 32'd1);
    steps(3);

    // backpressure on beat 2
    go(3'd0, 3'd7);
    steps(2);
    dout_ready = 1'b0;
    steps(3);
    chk("bp_hold_sel", {29'd0, dout_sel}, 32'd2);
    chk("bp_hold_dout", {16'd0, dout}, 32'h0000_1002);
    dout_ready = 1'b1;
    steps(5);
    chk("bp_b7_sel", {29'd0, dout_sel}, 32'd7);
    step();
    chk("bp_done", {31'd0, done}, 32'd1);
    steps(2);

    // single beat with lane changed after start
    din[5] = 16'hA5A5;
    go(3'd5, 3'd0);
    din[5] = 16'h5A5A;
    chk("single_dout", {16'd0, dout}, 32'h0000_A5A5);
    chk("single_last", {31'd0, dout_last}, 32'd1);
    step();
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_hold", {16'd0, dout}, 32'h0000_A5A5);
    steps(2);

    // start while busy, including on the last accepted beat
    go(3'd0, 3'd3);
    start = 1'b1; start_sel = 3'd4; len = 3'd6;
    step();
    start = 1'b0;
    step();
    start = 1'b1; start_sel = 3'd4; len = 3'd1;
    step();
    chk("busy_b3_sel", {29'd0, dout_sel}, 32'd3);
    step();
    chk("busy_ignored_done", {31'd0, done}, 32'd1);
    start_sel = 3'd2; len = 3'd1;
    step();
    start = 1'b0;
    chk("done_cycle_start_sel", {29'd0, dout_sel}, 32'd2);
    steps(3);

    // clear via en during beat 4
    go(3'd0, 3'd7);
    steps(4);
    en = 1'b0;
    step();
    chk("en_clr_dout", {16'd0, dout}, 32'd0);
    en = 1'b1;
    steps(2);
    go(3'd3, 3'd1);
    steps(3);

    // clear via sys_rst_n during beat 4
    go(3'd1, 3'd7);
    steps(4);
    sys_rst_n = 1'b0;
    step();
    chk("rst_clr_busy", {31'd0, busy}, 32'd0);
    sys_rst_n = 1'b1;
    steps(2);
    go(3'd7, 3'd2);
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
